// File: rtl/reg_scan_reader_pkg.sv
// -----------------------------------------------------------------------------
// reg_scan_reader_pkg
// Shared definitions for the register scan reader: register-file geometry,
// the controller state encoding and the scan-order helper.
// -----------------------------------------------------------------------------
package reg_scan_reader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_OFFER,
        ST_DWELL
    } scan_state_t;

    // Next register in auto-scan order; the last register wraps to index 0.
    function automatic logic [REG_ADDR_W-1:0] next_index(input logic [REG_ADDR_W-1:0] idx);
        return (idx == REG_ADDR_W'(REG_COUNT - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/reg_scan_reader_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Counts the cycles spent holding a displayed register value. The count is
// cleared by 'clear', advances while 'enable' is high and stops at DWELL-1,
// where 'done' is raised. Because it saturates it never wraps.
//
// Ports
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   clear  : return the count to zero (takes priority over enable)
//   enable : advance the count by one per cycle
//   done   : high while the count sits at DWELL-1 (last dwell cycle)
// -----------------------------------------------------------------------------
module dwell_timer
    import reg_scan_reader_pkg::*;
#(
    parameter int unsigned DWELL = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !done) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == LAST);

endmodule

// File: rtl/reg_scan_reader.sv
// -----------------------------------------------------------------------------
// reg_scan_reader
// Reads one register at a time from a register file and offers its index and
// value to a display sink over a valid/ready handshake. After the sink accepts,
// the value is held for DWELL cycles before the next register is fetched,
// either the next one in order (auto-scan) or the one chosen on sw_sel.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-low
//   scan_en    : 1 = auto-scan, 0 = manual selection via sw_sel
//   sw_sel     : manual register index
//   rf_addr    : register file read address (index being fetched)
//   rf_rdata   : combinational read data for rf_addr
//   disp_valid : offer to the display sink present
//   disp_ready : sink accepts the offer
//   disp_addr  : index of the offered register
//   disp_data  : captured value of the offered register
// -----------------------------------------------------------------------------
module reg_scan_reader
    import reg_scan_reader_pkg::*;
#(
    parameter int unsigned DWELL = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_en,
    input  logic [REG_ADDR_W-1:0] sw_sel,
    output logic [REG_ADDR_W-1:0] rf_addr,
    input  logic [REG_DATA_W-1:0] rf_rdata,
    output logic                  disp_valid,
    input  logic                  disp_ready,
    output logic [REG_ADDR_W-1:0] disp_addr,
    output logic [REG_DATA_W-1:0] disp_data
);

    scan_state_t           r_state;
    scan_state_t           w_state_nxt;
    logic [REG_ADDR_W-1:0] r_cur;
    logic [REG_ADDR_W-1:0] w_cur_nxt;
    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [REG_DATA_W-1:0] r_data;

    logic w_capture;
    logic w_handshake;
    logic w_abort;
    logic w_dwell_done;

    // The index register drives the read port directly, so the address is
    // already stable for the whole FETCH cycle.
    assign rf_addr    = r_cur;
    assign disp_valid = r_valid;
    assign disp_addr  = r_addr;
    assign disp_data  = r_data;

    // disp_ready only matters while an offer is outstanding.
    assign w_handshake = (r_state == ST_OFFER) && r_valid && disp_ready;

    // A manual selection that moves away from the register on display cuts
    // the dwell short so the new choice appears without waiting.
    assign w_abort = (r_state == ST_DWELL) && !scan_en && (sw_sel != r_cur);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_handshake),
        .enable (r_state == ST_DWELL),
        .done   (w_dwell_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only reached with reset released; cur is already 0.
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_OFFER;
            end
            ST_OFFER: begin
                if (w_handshake) begin
                    w_state_nxt = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (w_abort) begin
                    w_cur_nxt   = sw_sel;
                    w_state_nxt = ST_FETCH;
                end else if (w_dwell_done) begin
                    w_cur_nxt   = scan_en ? next_index(r_cur) : sw_sel;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
        end
    end

    // Offer registers: loaded at the end of FETCH, held through OFFER, and
    // valid drops on acceptance. Reset discards any pending offer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_addr  <= r_cur;
            r_data  <= rf_rdata;
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_scan_reader.sv
module tb_reg_scan_reader;

    localparam int unsigned DWELL_A = 4;
    localparam int unsigned DWELL_B = 1;

    logic        clk = 1'b0;
    logic        reset_a = 1'b0;
    logic        reset_b = 1'b0;
    logic        scan_en = 1'b1;
    logic [4:0]  sw_sel = 5'd0;
    logic        disp_ready = 1'b0;
    logic        sel = 1'b0;

    logic [4:0]  rf_addr_a, rf_addr_b, disp_addr_a, disp_addr_b;
    logic [31:0] rf_rdata_a, rf_rdata_b, disp_data_a, disp_data_b;
    logic        disp_valid_a, disp_valid_b;

    logic        o_valid;
    logic [4:0]  o_addr, o_rf_addr;
    logic [31:0] o_data;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rise = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return {27'd0, a} * 32'h01010101;
    endfunction

    assign rf_rdata_a = rf_val(rf_addr_a);
    assign rf_rdata_b = rf_val(rf_addr_b);

    assign o_valid   = sel ? disp_valid_b : disp_valid_a;
    assign o_addr    = sel ? disp_addr_b  : disp_addr_a;
    assign o_data    = sel ? disp_data_b  : disp_data_a;
    assign o_rf_addr = sel ? rf_addr_b    : rf_addr_a;

    reg_scan_reader #(.DWELL(DWELL_A)) dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .scan_en    (scan_en),
        .sw_sel     (sw_sel),
        .rf_addr    (rf_addr_a),
        .rf_rdata   (rf_rdata_a),
        .disp_valid (disp_valid_a),
        .disp_ready (disp_ready),
        .disp_addr  (disp_addr_a),
        .disp_data  (disp_data_a)
    );

    reg_scan_reader #(.DWELL(DWELL_B)) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .scan_en    (scan_en),
        .sw_sel     (sw_sel),
        .rf_addr    (rf_addr_b),
        .rf_rdata   (rf_rdata_b),
        .disp_valid (disp_valid_b),
        .disp_ready (disp_ready),
        .disp_addr  (disp_addr_b),
        .disp_data  (disp_data_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push the expected offer, wait (bounded) for disp_valid, pop and compare.
    // exp_period > 0 also checks the cycles since the previous offer appeared.
    task automatic get_offer(input logic [4:0] exp_addr, input int exp_period, input bit consume);
        exp_t e;
        bit   found;
        found = 1'b0;
        sb.push_back('{addr: exp_addr, data: rf_val(exp_addr)});
        for (int n = 0; n < 64 && !found; n++) begin
            if (o_valid) found = 1'b1;
            else step();
        end
        chk("offer_seen", {31'd0, found}, 32'd1);
        e = sb.pop_front();
        if (found) begin
            chk("offer_addr", {27'd0, o_addr}, {27'd0, e.addr});
            chk("offer_data", o_data, e.data);
            if (exp_period > 0) chk("period", cyc - last_rise, exp_period);
            last_rise = cyc;
        end
        if (consume) step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held three cycles: everything at zero.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rf_addr", {27'd0, rf_addr_a}, 32'd0);
        chk("rst_valid", {31'd0, disp_valid_a}, 32'd0);
        chk("rst_disp_addr", {27'd0, disp_addr_a}, 32'd0);
        chk("rst_disp_data", disp_data_a, 32'd0);

        // Release: FETCH of register 0 on the first edge, offer on the second.
        reset_a = 1'b1;
        step();
        chk("fetch0_rf_addr", {27'd0, rf_addr_a}, 32'd0);
        chk("fetch0_valid", {31'd0, disp_valid_a}, 32'd0);
        step();
        chk("offer0_valid", {31'd0, disp_valid_a}, 32'd1);
        get_offer(5'd0, 0, 1'b0);

        // Auto-scan with ready high: registers 1..4, period DWELL+2.
        disp_ready = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) get_offer(5'(i), DWELL_A + 2, 1'b1);

        // Stall register 5 for ten cycles.
        disp_ready = 1'b0;
        get_offer(5'd5, DWELL_A + 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_addr", {27'd0, o_addr}, 32'd5);
            chk("stall_data", o_data, rf_val(5'd5));
        end
        disp_ready = 1'b1;
        step();
        chk("stall_release_valid", {31'd0, o_valid}, 32'd0);

        // Remainder of the scan, wrapping 31 -> 0.
        get_offer(5'd6, 0, 1'b1);
        for (int i = 7; i <= 32; i++) get_offer(5'(i % 32), DWELL_A + 2, 1'b1);

        // Manual mode: select 7, then change to 12 two cycles into the dwell.
        scan_en = 1'b0;
        sw_sel  = 5'd7;
        get_offer(5'd7, 0, 1'b1);
        step();
        sw_sel = 5'd12;
        step();
        chk("abort_rf_addr", {27'd0, o_rf_addr}, 32'd12);
        chk("abort_fetch_valid", {31'd0, o_valid}, 32'd0);
        step();
        chk("abort_offer_valid", {31'd0, o_valid}, 32'd1);
        get_offer(5'd12, 0, 1'b1);
        // Unchanged selection waits out the full dwell.
        get_offer(5'd12, DWELL_A + 2, 1'b1);

        // Reset during an offer at register 20.
        disp_ready = 1'b0;
        sw_sel = 5'd20;
        get_offer(5'd20, 0, 1'b0);
        reset_a = 1'b0;
        step();
        chk("midreset_valid", {31'd0, disp_valid_a}, 32'd0);
        chk("midreset_disp_addr", {27'd0, disp_addr_a}, 32'd0);
        chk("midreset_rf_addr", {27'd0, rf_addr_a}, 32'd0);
        chk("midreset_disp_data", disp_data_a, 32'd0);

        // DWELL=1 instance: three-cycle period and wrap.
        sel = 1'b1;
        chk("b_rst_valid", {31'd0, disp_valid_b}, 32'd0);
        scan_en = 1'b1;
        disp_ready = 1'b1;
        reset_b = 1'b1;
        for (int i = 0; i <= 32; i++) get_offer(5'(i % 32), (i > 0) ? int'(DWELL_B + 2) : 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scan_reader.md
REG_SCAN_READER -- requirements
Module: reg_scan_reader

Interface
REQ-001 The block SHALL have parameter DWELL, default 25_000_000, giving the cycles a register value is held after handshake (legal range 1..2^26).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port scan_en, input, 1 bit: 1 selects auto-scan; 0 selects manual select.
REQ-005 The block SHALL have port sw_sel, input, 5 bits: manual register index, sampled only when scan_en=0.
REQ-006 The block SHALL have port rf_addr, output, 5 bits: read address to the register file read port.
REQ-007 The block SHALL have port rf_rdata, input, 32 bits: combinational read data returned for rf_addr.
REQ-008 The block SHALL have port disp_valid, output, 1 bit: an offer to the display sink is present.
REQ-009 The block SHALL have port disp_ready, input, 1 bit: the sink accepts the offer.
REQ-010 The block SHALL have port disp_addr, output, 5 bits: index of the offered register.
REQ-011 The block SHALL have port disp_data, output, 32 bits: captured value of the offered register.

Function
REQ-012 The FSM SHALL have states IDLE, FETCH, OFFER and DWELL.
REQ-013 IDLE SHALL go to FETCH on the first cycle with reset=1.
REQ-014 On entry to FETCH, rf_addr SHALL already hold the target index (cur).
REQ-015 At the end of FETCH: disp_data<=rf_rdata, disp_addr<=cur, disp_valid<=1, next state OFFER; disp_valid rises exactly one cycle after rf_addr changes.
REQ-016 In OFFER, disp_valid, disp_addr and disp_data SHALL stay stable until disp_ready=1 is sampled.
REQ-017 A handshake SHALL be disp_valid=1 and disp_ready=1 in the same cycle; on handshake disp_valid<=0, the dwell counter clears and the next state is DWELL.
REQ-018 disp_ready SHALL be ignored outside OFFER.
REQ-019 DWELL SHALL last DWELL cycles; then next cur is (cur+1) mod 32 if scan_en=1 (31 wraps to 0), else sw_sel; next state FETCH.
REQ-020 scan_en and sw_sel SHALL be evaluated only at DWELL exit, except as REQ-021 states.
REQ-021 In DWELL with scan_en=0, a sw_sel value differing from the last fetched index SHALL abort the dwell: the next cycle is FETCH with cur=sw_sel.
REQ-022 A scan_en change during FETCH or OFFER SHALL not alter the current offer.
REQ-023 With disp_ready tied 1, the auto-scan period SHALL be DWELL+2 cycles per register.
REQ-024 The dwell counter width SHALL be $clog2(DWELL+1) and the counter SHALL not overflow.

Reset
REQ-025 While reset=0 at a clock edge: state IDLE, cur=0, rf_addr=0, disp_valid=0, disp_addr=0, disp_data=0, counter=0.
REQ-026 Reset asserted in any state, including mid-OFFER, SHALL take effect at the next edge and drop any pending offer without a handshake.

Structure
REQ-027 The shared package SHALL hold the state enum, REG_ADDR_W=5, REG_DATA_W=32 and REG_COUNT=32.
REQ-028 The dwell counter SHALL be sub-module dwell_timer (inputs clear and enable; output done).

Verification
REQ-029 The bench SHALL cover: reset=0 for 3 cycles -> all outputs 0; release -> rf_addr=0 and disp_valid=1 two edges later with disp_data=rf model[0].
REQ-030 The bench SHALL cover: DWELL=4, scan_en=1, ready=1, rf model[i]=i*32'h01010101 -> disp_addr runs 0..31 then 0, period 6 cycles, data matching the model.
REQ-031 The bench SHALL cover: disp_ready=0 for 10 cycles in OFFER at addr 5 -> valid, addr and data stable for 10 cycles; advance only after ready=1.
REQ-032 The bench SHALL cover: scan_en=0, sw_sel=7 offered, then sw_sel=12 two cycles into DWELL -> FETCH next cycle and disp_addr=12 one cycle later.
REQ-033 The bench SHALL cover: reset=0 during OFFER at addr 20 -> next edge disp_valid=0, disp_addr=0, rf_addr=0.
REQ-034 The bench SHALL cover: DWELL=1, ready=1 -> a 3-cycle period, and wrap 31->0 verified.
